// File: rtl/ucie_ctl_phy_csr_pkg.sv
// Shared definitions for the UCIe PHY CSR bank: word offsets,
// the CTRL.START bit position, the word type and the byte-enable merge helper.
package ucie_ctl_phy_csr_pkg;

   typedef logic [31:0] csr_word_t;

   // Word indices (byte address / 4)
   localparam int CSR_CAP_OFS    = 0;
   localparam int CSR_CTRL_OFS   = 4;
   localparam int CSR_STATUS_OFS = 5;

   localparam int CTRL_START_BIT = 10;

   // Replace the bytes of old_w selected by be with the matching bytes of new_w
   function automatic csr_word_t be_merge(
      input csr_word_t  old_w,
      input csr_word_t  new_w,
      input logic [3:0] be
   );
      csr_word_t r;
      r = old_w;
      for (int n = 0; n < 4; n++) begin
         if (be[n]) r[8*n +: 8] = new_w[8*n +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/ucie_ctl_phy_csr_w1c.sv
// STATUS register: per-bit hardware set with write-1-to-clear; set beats clear.
// Ports: i_clk, i_rst_n, set (HW set pulses), clr (SW clear mask), status (contents).
module ucie_ctl_phy_csr_w1c
   import ucie_ctl_phy_csr_pkg::*;
#(
   parameter int STS_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [STS_W-1:0] set,
   input  logic [STS_W-1:0] clr,
   output logic [STS_W-1:0] status
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         status <= '0;
      end else begin
         status <= set | (status & ~clr);
      end
   end

endmodule

// File: rtl/ucie_ctl_phy_csr_bank.sv
// Word-organised PHY control/status register bank with byte-enabled writes,
// registered reads, error reporting, self-clearing CTRL.START and W1C STATUS.
// Ports: i_req/i_WR/i_addr/i_WDATA/i_BE access request; o_RDATA/o_rvalid/o_err
// completion one cycle later; i_clear_start_training_bit and i_status_set are
// hardware inputs; o_start_ucie_link_training and o_status reflect CTRL.START and STATUS.
module ucie_ctl_phy_csr_bank
   import ucie_ctl_phy_csr_pkg::*;
#(
   parameter int        NUM_WORDS = 16,
   parameter int        ADDR_W    = 8,
   parameter int        STS_W     = 8,
   parameter csr_word_t CAP_VALUE = 32'h0001_0001
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req,
   input  logic              i_WR,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_WDATA,
   input  logic [3:0]        i_BE,
   input  logic              i_clear_start_training_bit,
   input  logic [STS_W-1:0]  i_status_set,
   output logic [31:0]       o_RDATA,
   output logic              o_rvalid,
   output logic              o_err,
   output logic              o_start_ucie_link_training,
   output logic [STS_W-1:0]  o_status
);

   localparam int IDX_W = $clog2(NUM_WORDS);

   localparam logic [IDX_W-1:0] CAP_IDX  = IDX_W'(CSR_CAP_OFS);
   localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(CSR_CTRL_OFS);
   localparam logic [IDX_W-1:0] STS_IDX  = IDX_W'(CSR_STATUS_OFS);

   csr_word_t         mem [NUM_WORDS];
   logic [ADDR_W-3:0] word_idx;
   logic [IDX_W-1:0]  idx;
   logic              acc_err;
   logic              wr_ok;
   logic              rd_ok;
   logic              is_cap;
   logic              is_ctrl;
   logic              is_sts;
   csr_word_t         wmask;
   csr_word_t         rd_word;
   logic [STS_W-1:0]  sts_clr;
   logic [STS_W-1:0]  status;

   assign word_idx = i_addr[ADDR_W-1:2];
   assign idx      = word_idx[IDX_W-1:0];

   // Index compared one bit wider so NUM_WORDS == 2**(ADDR_W-2) still fits
   assign acc_err = (|i_addr[1:0]) ||
                    ({1'b0, word_idx} >= (ADDR_W-1)'(NUM_WORDS));

   assign wr_ok   = i_req & i_WR & ~acc_err;
   assign rd_ok   = i_req & ~i_WR & ~acc_err;
   assign is_cap  = (idx == CAP_IDX);
   assign is_ctrl = (idx == CTRL_IDX);
   assign is_sts  = (idx == STS_IDX);

   assign wmask   = be_merge('0, i_WDATA, i_BE);
   assign sts_clr = (wr_ok && is_sts) ? wmask[STS_W-1:0] : '0;

   ucie_ctl_phy_csr_w1c #(
      .STS_W (STS_W)
   ) u_status (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .set     (i_status_set),
      .clr     (sts_clr),
      .status  (status)
   );

   always_comb begin
      rd_word = mem[idx];
      if (is_cap) begin
         rd_word = CAP_VALUE;
      end else if (is_sts) begin
         rd_word = 32'(status);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
      end else begin
         if (wr_ok && !is_cap && !is_sts) begin
            mem[idx] <= be_merge(mem[idx], i_WDATA, i_BE);
         end
         // HW clear only when no SW write to the START byte this cycle
         if (i_clear_start_training_bit &&
             !(wr_ok && is_ctrl && i_BE[1])) begin
            mem[CTRL_IDX][CTRL_START_BIT] <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rvalid <= 1'b0;
         o_err    <= 1'b0;
         o_RDATA  <= '0;
      end else begin
         o_rvalid <= i_req;
         o_err    <= i_req & acc_err;
         o_RDATA  <= rd_ok ? rd_word : '0;
      end
   end

   assign o_start_ucie_link_training = mem[CTRL_IDX][CTRL_START_BIT];
   assign o_status = status;

endmodule

// File: tb/tb_ucie_ctl_phy_csr_bank.sv
// Directed bench for ucie_ctl_phy_csr_bank: CAP/CTRL/STATUS/scratch access,
// START and W1C priority, errors, back-to-back reads and mid-access reset.
module tb_ucie_ctl_phy_csr_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        wr;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        clr_start;
   logic [7:0]  sts_set;
   logic [31:0] rdata;
   logic        rvalid;
   logic        err;
   logic        start;
   logic [7:0]  status;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ucie_ctl_phy_csr_bank #(
      .NUM_WORDS (16),
      .ADDR_W    (8),
      .STS_W     (8),
      .CAP_VALUE (32'h0001_0001)
   ) dut (
      .i_clk                      (clk),
      .i_rst_n                    (rst_n),
      .i_req                      (req),
      .i_WR                       (wr),
      .i_addr                     (addr),
      .i_WDATA                    (wdata),
      .i_BE                       (be),
      .i_clear_start_training_bit (clr_start),
      .i_status_set               (sts_set),
      .o_RDATA                    (rdata),
      .o_rvalid                   (rvalid),
      .o_err                      (err),
      .o_start_ucie_link_training (start),
      .o_status                   (status)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Issue one access at a negedge; returns at the next negedge,
   // where the completion is visible.
   task automatic access(input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] b);
      req   = 1'b1;
      wr    = w;
      addr  = a;
      wdata = d;
      be    = b;
      @(negedge clk);
      req   = 1'b0;
      wr    = 1'b0;
      wdata = '0;
      be    = '0;
   endtask

   task automatic check_cpl(input string tag, input logic [31:0] d,
                            input logic e);
      check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
      check({tag, "_err"},    32'(err),    32'(e));
      check({tag, "_rdata"},  rdata,       d);
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = 1'b0;
      wr        = 1'b0;
      addr      = '0;
      wdata     = '0;
      be        = '0;
      clr_start = 1'b0;
      sts_set   = '0;
      #12;
      check("rst_rdata",  rdata,         32'd0);
      check("rst_rvalid", 32'(rvalid),   32'd0);
      check("rst_err",    32'(err),      32'd0);
      check("rst_start",  32'(start),    32'd0);
      check("rst_status", 32'(status),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // CAP and CTRL reads
      access(1'b0, 8'h00, '0, '0);
      check_cpl("rd_cap", 32'h0001_0001, 1'b0);
      @(negedge clk);
      check("idle_rvalid", 32'(rvalid), 32'd0);
      check("idle_rdata",  rdata,       32'd0);
      access(1'b0, 8'h10, '0, '0);
      check_cpl("rd_ctrl0", 32'd0, 1'b0);

      // START set, HW clear, same-cycle write vs clear
      access(1'b1, 8'h10, 32'h0000_0400, 4'b0010);
      check_cpl("wr_ctrl", 32'd0, 1'b0);
      check("start_set", 32'(start), 32'd1);
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      check("start_hwclr", 32'(start), 32'd0);
      clr_start = 1'b1;
      access(1'b1, 8'h10, 32'h0000_0400, 4'b0010);
      clr_start = 1'b0;
      check("start_sw_wins", 32'(start), 32'd1);

      // Byte-enabled scratch write
      access(1'b1, 8'h18, 32'hA5A5_A5A5, 4'b0101);
      access(1'b0, 8'h18, '0, '0);
      check_cpl("rd_scratch", 32'h00A5_00A5, 1'b0);
      access(1'b1, 8'h18, 32'hFFFF_FFFF, 4'b0000);
      check_cpl("wr_be0", 32'd0, 1'b0);
      access(1'b0, 8'h18, '0, '0);
      check_cpl("rd_be0", 32'h00A5_00A5, 1'b0);

      // STATUS set and W1C
      sts_set = 8'h81;
      @(negedge clk);
      sts_set = 8'h00;
      check("sts_set", 32'(status), 32'h81);
      access(1'b1, 8'h14, 32'h0000_0001, 4'b0001);
      check("sts_w1c", 32'(status), 32'h80);
      access(1'b1, 8'h14, 32'h0000_0080, 4'b0000);
      check("sts_w1c_be0", 32'(status), 32'h80);
      sts_set = 8'h01;
      access(1'b1, 8'h14, 32'h0000_0001, 4'b0001);
      sts_set = 8'h00;
      check("sts_set_wins", 32'(status), 32'h81);
      access(1'b0, 8'h14, '0, '0);
      check_cpl("rd_sts", 32'h0000_0081, 1'b0);

      // Errors: misaligned read/write, out of range
      access(1'b0, 8'h13, '0, '0);
      check_cpl("rd_misal", 32'd0, 1'b1);
      access(1'b1, 8'h11, 32'd0, 4'b1111);
      check_cpl("wr_misal", 32'd0, 1'b1);
      check("misal_nochg", 32'(start), 32'd1);
      access(1'b0, 8'h40, '0, '0);
      check_cpl("rd_oor", 32'd0, 1'b1);
      access(1'b1, 8'h54, 32'hFFFF_FFFF, 4'b1111);
      check_cpl("wr_oor", 32'd0, 1'b1);
      check("oor_nochg", 32'(status), 32'h81);

      // Back-to-back reads
      req  = 1'b1;
      wr   = 1'b0;
      addr = 8'h00;
      @(negedge clk);
      check_cpl("b2b_0", 32'h0001_0001, 1'b0);
      addr = 8'h10;
      @(negedge clk);
      req = 1'b0;
      check_cpl("b2b_1", 32'h0000_0400, 1'b0);
      @(negedge clk);
      check("b2b_end", 32'(rvalid), 32'd0);

      // Reset with a completion pending
      req  = 1'b1;
      wr   = 1'b0;
      addr = 8'h00;
      @(posedge clk);
      #1;
      req   = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mr_rvalid", 32'(rvalid), 32'd0);
      check("mr_rdata",  rdata,       32'd0);
      check("mr_start",  32'(start),  32'd0);
      check("mr_status", 32'(status), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mr_no_cpl", 32'(rvalid), 32'd0);
      access(1'b0, 8'h18, '0, '0);
      check_cpl("mr_scratch", 32'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
